axi_config_wr: RTL and testbench
================================

# axi_config_wr

AXI4 write-channel slave that turns AXI write bursts into single-cycle register-bus write strobes (`wr`/`waddr`/`wdata`/`wstrb`). It is the write-side companion of the config read slave and sits between the AXI interconnect and a block's configuration register file. One beat per cycle throughput, fire-and-forget towards the register side, a single OKAY response per burst.

## Interface
- `ADDR_WIDTH`, 32, address width in bits
- `DATA_WIDTH`, 32, data width in bits
- `STRB_WIDTH`, `DATA_WIDTH/8`, byte strobe width; must be a power of two with `STRB_WIDTH*8 == DATA_WIDTH`, elaboration error otherwise
- `ID_WIDTH`, 8, AXI ID width
- `BUSER_WIDTH`, 1, width of `s_axi_buser`, driven to 0
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `s_axi_awid`/`awaddr`/`awlen`  in  `ID_WIDTH`/`ADDR_WIDTH`/8  captured on AW handshake
- `s_axi_awsize`/`awburst`/`awlock`/`awcache`/`awprot`/`awqos`/`awregion`  in  3/2/1/4/3/4/4  ignored
- `s_axi_awvalid`  in  1;  `s_axi_awready`  out  1
- `s_axi_wdata`  in  `DATA_WIDTH`;  `s_axi_wstrb`  in  `STRB_WIDTH`;  `s_axi_wlast`  in  1
- `s_axi_wvalid`  in  1;  `s_axi_wready`  out  1
- `s_axi_bid`  out  `ID_WIDTH`;  `s_axi_bresp`  out  2;  `s_axi_buser`  out  `BUSER_WIDTH`
- `s_axi_bvalid`  out  1;  `s_axi_bready`  in  1
- `wr`  out  1  one-cycle write strobe per accepted beat
- `waddr`  out  `ADDR_WIDTH`  beat address, valid with `wr`, held otherwise
- `wdata`  out  `DATA_WIDTH`;  `wstrb`  out  `STRB_WIDTH`  beat data/strobes, valid with `wr`

## Operation
- States: IDLE, DATA, RESP.
- IDLE: `awready`=1. On `awvalid&&awready`: capture id, addr, count=awlen; go DATA.
- DATA: `wready`=1. On `wvalid&&wready`: register `wr`=1, `waddr`=addr, `wdata`, `wstrb`; addr += `STRB_WIDTH` (modulo 2^`ADDR_WIDTH`, always INCR regardless of `awburst`/`awsize`); if count==0 go RESP, else count -= 1.
- RESP: `bvalid`=1, `bid`=captured id, `bresp`=OKAY (2'b00) unless overridden by the configured check. On `bvalid&&bready`: go IDLE.
- Only one outstanding burst; AW not accepted until B completes.
- Register side has no backpressure; `wr` is never stalled.
- `wstrb`=0 beats still produce `wr`=1 with `wstrb`=0.

## Timing
- Reset values: `awready`=0, `wready`=0, `bvalid`=0, `bresp`=0, `bid`=0, `wr`=0, `waddr`=0, `wdata`=0, `wstrb`=0, state IDLE.
- `awready` rises the first cycle after `rst` deasserts.
- AW handshake at cycle N: `awready`=0 and `wready`=1 at N+1.
- W handshake at cycle M: `wr`=1 with beat address/data at M+1 (1-cycle latency); back-to-back beats give back-to-back `wr`.
- Last beat at M: `wready`=0, `bvalid`=1 at M+1, concurrent with that beat's `wr`.
- B handshake at K: `bvalid`=0, `awready`=1 at K+1. Minimum burst-to-burst gap: AW accepted at K+1 earliest.
- `bvalid` held with stable `bid`/`bresp` until `bready`.
- `rst` mid-burst: next cycle all outputs at reset values; no `wr` for unaccepted beats, no B response for aborted burst.
- Address wrap: addr 0xFFFF_FFFC + 4 -> 0x0000_0000 (ADDR_WIDTH=32, STRB_WIDTH=4).

## Configuration
- `AXI_CONFIG_WR_WLAST_CHECK_EN` defined: `wlast` compared against expected last beat (count==0) on every accepted beat; any mismatch sets a sticky error, and `bresp`=SLVERR (2'b10) for that burst. Burst length still governed by `awlen` only; all beats still produce `wr`. Error cleared on entering IDLE.
- Not defined: `wlast` ignored, `bresp` always OKAY.

## Test plan
- Single beat: AW addr=0x100, len=0, id=0x5; W data=0xDEADBEEF strb=0xF -> one `wr` with waddr=0x100, wdata=0xDEADBEEF; B bid=0x5, bresp=0.
- 4-beat burst, `wvalid` continuous: addr=0x40, len=3 -> `wr` on 4 consecutive cycles, waddr 0x40/0x44/0x48/0x4C; single B.
- W gaps and B backpressure: `wvalid` toggled, `bready` low 5 cycles -> `wr` only on accepted beats, `bvalid` held 5 cycles, no AW accepted until B handshake.
- Address wrap: addr=0xFFFFFFF8, len=2 -> waddr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-burst: `rst` after 2 of 4 beats -> all outputs 0 next cycle, no B; new single-beat burst afterwards completes normally.
- With `AXI_CONFIG_WR_WLAST_CHECK_EN`: len=1, `wlast` on first beat -> 2 `wr`, bresp=2'b10; next correct burst -> bresp=0.

Source files
------------

// File: rtl/axi_config_wr_if.sv
// AXI4 write-channel bundle (AW/W/B) for axi_config_wr.
// The slave modport is the register-bus side; master is the interconnect side.
interface axi_config_wr_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned BUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]    awid;
  logic [ADDR_WIDTH-1:0]  awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awlock;
  logic [3:0]             awcache;
  logic [2:0]             awprot;
  logic [3:0]             awqos;
  logic [3:0]             awregion;
  logic                   awvalid;
  logic                   awready;

  logic [DATA_WIDTH-1:0]  wdata;
  logic [STRB_WIDTH-1:0]  wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [ID_WIDTH-1:0]    bid;
  logic [1:0]             bresp;
  logic [BUSER_WIDTH-1:0] buser;
  logic                   bvalid;
  logic                   bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
    input  awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
    output awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_config_wr.sv
// AXI4 write slave turning bursts into single-cycle register-bus write strobes.
// Optional wlast checking (SLVERR on mismatch) is enabled by AXI_CONFIG_WR_WLAST_CHECK_EN.
module axi_config_wr #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned BUSER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_config_wr_if.slave        s_axi,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb
);

  if (STRB_WIDTH == 0 || (STRB_WIDTH & (STRB_WIDTH - 1)) != 0 || STRB_WIDTH * 8 != DATA_WIDTH)
  begin : g_bad_strb
    $error("axi_config_wr: STRB_WIDTH must be a power of two equal to DATA_WIDTH/8");
  end

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            count_q, count_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

  logic aw_hs, w_hs, b_hs, last_beat;

  assign aw_hs     = s_axi.awvalid & awready_q;
  assign w_hs      = s_axi.wvalid & wready_q;
  assign b_hs      = s_axi.bready & bvalid_q;
  assign last_beat = (count_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      id_q      <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (aw_hs) begin
          state_d = StData;
          id_d    = s_axi.awid;
          addr_d  = s_axi.awaddr;
          count_d = s_axi.awlen;
          err_d   = 1'b0;
        end
      end
      StData: begin
        if (w_hs) begin
          // Always INCR by one bus word; awburst/awsize are deliberately ignored.
          addr_d = addr_q + ADDR_WIDTH'(STRB_WIDTH);
`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
          err_d = err_q | (s_axi.wlast != last_beat);
`endif
          if (last_beat) begin
            state_d = StResp;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
      end
      StResp: begin
        if (b_hs) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs are registered from the next state so they drop to 0 in reset.
  always_comb begin
    awready_d = (state_d == StIdle);
    wready_d  = (state_d == StData);
    bvalid_d  = (state_d == StResp);
    bresp_d   = (state_d == StResp && err_d) ? 2'b10 : 2'b00;
    wr_d      = w_hs;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (w_hs) begin
      waddr_d = addr_q;
      wdata_d = s_axi.wdata;
      wstrb_d = s_axi.wstrb;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = id_q;
  assign s_axi.buser   = {BUSER_WIDTH{1'b0}};

  assign wr    = wr_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;

endmodule

// File: tb/tb_axi_config_wr.sv
// Randomized bench for axi_config_wr: expected register writes and B responses come from a
// burst-level model (base + i*STRB_WIDTH, wlast rule); define AXI_CONFIG_WR_WLAST_CHECK_EN to match RTL.
module tb_axi_config_wr;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned BW = 1;

  logic          clk;
  logic          rst;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;

  axi_config_wr_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (SW),
    .ID_WIDTH   (IW),
    .BUSER_WIDTH(BW)
  ) s_axi ();

  axi_config_wr #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .STRB_WIDTH (SW),
    .ID_WIDTH   (IW),
    .BUSER_WIDTH(BW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_axi(s_axi),
    .wr   (wr),
    .waddr(waddr),
    .wdata(wdata),
    .wstrb(wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected register writes, each due at a given cycle count.
  typedef struct {
    int unsigned   due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      check("wr", wr, 1);
      check("waddr", waddr, exp_q[0].addr);
      check("wdata", wdata, exp_q[0].data);
      check("wstrb", wstrb, exp_q[0].strb);
      void'(exp_q.pop_front());
    end else begin
      check("wr_idle", wr, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check_reset_outputs();
    check("rst_awready", s_axi.awready, 0);
    check("rst_wready", s_axi.wready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_bresp", s_axi.bresp, 0);
    check("rst_bid", s_axi.bid, 0);
    check("rst_buser", s_axi.buser, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    bit hs = 1'b0;
    int n  = 0;
    s_axi.awid     = id;
    s_axi.awaddr   = addr;
    s_axi.awlen    = len;
    s_axi.awsize   = 3'($urandom);
    s_axi.awburst  = 2'($urandom);
    s_axi.awlock   = 1'($urandom);
    s_axi.awcache  = 4'($urandom);
    s_axi.awprot   = 3'($urandom);
    s_axi.awqos    = 4'($urandom);
    s_axi.awregion = 4'($urandom);
    s_axi.awvalid  = 1'b1;
    while (!hs && n < 64) begin
      @(negedge clk);
      hs = s_axi.awready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axi.awvalid = 1'b0;
    check("aw_accept", hs, 1);
    @(negedge clk);
    check("aw_ready_low", s_axi.awready, 0);
    check("w_ready_high", s_axi.wready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input bit last, input int gap);
    repeat (gap) begin
      @(negedge clk);
      check("w_ready_gap", s_axi.wready, 1);
      @(posedge clk);
      #1;
    end
    s_axi.wdata  = data;
    s_axi.wstrb  = strb;
    s_axi.wlast  = last;
    s_axi.wvalid = 1'b1;
    @(negedge clk);
    check("w_ready", s_axi.wready, 1);
    exp_q.push_back('{due: cyc + 1, addr: addr, data: data, strb: strb});
    @(posedge clk);
    #1;
    s_axi.wvalid = 1'b0;
  endtask

  // bad: index of the beat whose wlast is inverted, or -1 for a well-formed burst.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input bit gaps, input int bad, input int bstall,
                           input logic [31:0] d0, input logic [3:0] s0);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  exp_resp;
    bit          err = 1'b0;
    bit          last;
    send_aw(id, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      a    = addr + 32'(i * 4);
      d    = (i == 0) ? d0 : $urandom;
      s    = (i == 0) ? s0 : 4'($urandom);
      last = (i == int'(len)) ^ (i == bad);
      if (i == bad) err = 1'b1;
      send_w(a, d, s, last, gaps ? int'($urandom_range(0, 2)) : 0);
    end
`ifdef AXI_CONFIG_WR_WLAST_CHECK_EN
    exp_resp = err ? 2'b10 : 2'b00;
`else
    exp_resp = 2'b00;
`endif
    @(negedge clk);
    check("w_ready_done", s_axi.wready, 0);
    check("b_valid", s_axi.bvalid, 1);
    check("b_id", s_axi.bid, id);
    check("b_resp", s_axi.bresp, exp_resp);
    @(posedge clk);
    #1;
    repeat (bstall) begin
      @(negedge clk);
      check("b_stall_valid", s_axi.bvalid, 1);
      check("b_stall_id", s_axi.bid, id);
      check("b_stall_resp", s_axi.bresp, exp_resp);
      check("b_stall_awready", s_axi.awready, 0);
      @(posedge clk);
      #1;
    end
    s_axi.bready = 1'b1;
    @(negedge clk);
    check("b_hs_valid", s_axi.bvalid, 1);
    @(posedge clk);
    #1;
    s_axi.bready = 1'b0;
    @(negedge clk);
    check("b_done", s_axi.bvalid, 0);
    check("aw_ready_back", s_axi.awready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    s_axi.awid     = '0;
    s_axi.awaddr   = '0;
    s_axi.awlen    = '0;
    s_axi.awsize   = '0;
    s_axi.awburst  = '0;
    s_axi.awlock   = '0;
    s_axi.awcache  = '0;
    s_axi.awprot   = '0;
    s_axi.awqos    = '0;
    s_axi.awregion = '0;
    s_axi.awvalid  = 1'b0;
    s_axi.wdata    = '0;
    s_axi.wstrb    = '0;
    s_axi.wlast    = 1'b0;
    s_axi.wvalid   = 1'b0;
    s_axi.bready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("aw_ready_pre_rise", s_axi.awready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("aw_ready_rise", s_axi.awready, 1);
    @(posedge clk);
    #1;

    // Directed scenarios
    run_burst(8'h05, 32'h0000_0100, 8'd0, 1'b0, -1, 0, 32'hDEAD_BEEF, 4'hF);
    run_burst(8'h11, 32'h0000_0040, 8'd3, 1'b0, -1, 0, $urandom, 4'hF);
    run_burst(8'h22, 32'h0000_0200, 8'd5, 1'b1, -1, 5, $urandom, 4'h3);
    run_burst(8'h33, 32'hFFFF_FFF8, 8'd2, 1'b0, -1, 1, $urandom, 4'hF);
    run_burst(8'h44, 32'h0000_0010, 8'd1, 1'b0, -1, 0, $urandom, 4'h0);

    // Reset after two of four beats: no B for the aborted burst.
    send_aw(8'h66, 32'h0000_0080, 8'd3);
    send_w(32'h0000_0080, $urandom, 4'hF, 1'b0, 0);
    send_w(32'h0000_0084, $urandom, 4'hF, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    run_burst(8'h67, 32'h0000_0500, 8'd0, 1'b0, -1, 0, $urandom, 4'hA);

    // Early wlast, then a well-formed burst.
    run_burst(8'h77, 32'h0000_0300, 8'd1, 1'b0, 0, 0, $urandom, 4'hF);
    run_burst(8'h78, 32'h0000_0310, 8'd1, 1'b0, -1, 0, $urandom, 4'hF);

    // Randomized bursts
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      logic [7:0]  rl;
      int          rb;
      rl = 8'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4))
                                       : ($urandom & 32'hFFFF_FFFC);
      rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
      run_burst(8'($urandom), ra, rl, 1'($urandom), rb, int'($urandom_range(0, 4)),
                $urandom, 4'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    check("exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
